// File: rtl/hs_tx_sequencer.sv
// D-PHY HS transmit lane sequencer: LP-11 > LP-01 > LP-00 > HS-zero > sync > data > trail > exit.
// Optional HS_BYTE_COUNT_EN adds Burst_Byte_Count (payload bytes in the current/last burst).
module hs_tx_sequencer #(
  parameter int         T_LPX        = 2,
  parameter int         T_HS_PREPARE = 2,
  parameter int         T_HS_ZERO    = 6,
  parameter int         T_HS_TRAIL   = 4,
  parameter int         T_HS_EXIT    = 3,
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         CNT_W        = 8
) (
  input  logic       TxByteClkHS,
  input  logic       TxRst,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic [7:0] TxByteHS_Data,
  output logic       Serializer_Enable,
  output logic       LP_Dp,
  output logic       LP_Dn,
`ifdef HS_BYTE_COUNT_EN
  output logic [15:0] Burst_Byte_Count,
`endif
  output logic       Burst_Active
);

  typedef enum logic [2:0] {
    IDLE, LPX, PREPARE, HS_ZERO,
    SYNC, DATA, TRAIL, EXIT
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_load;
  logic [7:0]         byte_q;
  logic               accept;
  logic               done;

  assign done   = (cnt_q == '0);
  assign accept = TxRequestHS &&
                  (state_q == SYNC || state_q == DATA);

  always_ff @(posedge TxByteClkHS or posedge TxRst) begin
    if (TxRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (TxRequestHS) state_d = LPX;
      LPX:     if (done) state_d = PREPARE;
      PREPARE: if (done) state_d = HS_ZERO;
      HS_ZERO: if (done) state_d = SYNC;
      SYNC:    state_d = TxRequestHS ? DATA : TRAIL;
      DATA:    state_d = TxRequestHS ? DATA : TRAIL;
      TRAIL:   if (done) state_d = EXIT;
      EXIT:    if (done) state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    unique case (state_d)
      LPX:     cnt_load = CNT_W'(T_LPX - 1);
      PREPARE: cnt_load = CNT_W'(T_HS_PREPARE - 1);
      HS_ZERO: cnt_load = CNT_W'(T_HS_ZERO - 1);
      TRAIL:   cnt_load = CNT_W'(T_HS_TRAIL - 1);
      EXIT:    cnt_load = CNT_W'(T_HS_EXIT - 1);
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge TxByteClkHS or posedge TxRst) begin
    if (TxRst)                  cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= cnt_load;
    else if (!done)             cnt_q <= cnt_q - 1'b1;
  end

  // byte_q holds the byte on the wire in SYNC/DATA; it is
  // left untouched on exit so TRAIL can invert its MSB
  always_ff @(posedge TxByteClkHS or posedge TxRst) begin
    if (TxRst)
      byte_q <= 8'h00;
    else if (state_q == HS_ZERO && state_d == SYNC)
      byte_q <= SYNC_BYTE;
    else if (accept)
      byte_q <= TxDataHS;
  end

`ifdef HS_BYTE_COUNT_EN
  always_ff @(posedge TxByteClkHS or posedge TxRst) begin
    if (TxRst)
      Burst_Byte_Count <= 16'h0000;
    else if (state_d == LPX && state_q != LPX)
      Burst_Byte_Count <= 16'h0000;
    else if (accept && Burst_Byte_Count != 16'hFFFF)
      Burst_Byte_Count <= Burst_Byte_Count + 16'h0001;
  end
`endif

  always_comb begin
    LP_Dp             = 1'b0;
    LP_Dn             = 1'b0;
    Serializer_Enable = 1'b0;
    TxByteHS_Data     = 8'h00;
    TxReadyHS         = 1'b0;
    Burst_Active      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        LP_Dp = 1'b1;
        LP_Dn = 1'b1;
      end
      LPX:     LP_Dn = 1'b1;
      PREPARE: ;
      HS_ZERO: Serializer_Enable = 1'b1;
      SYNC, DATA: begin
        Serializer_Enable = 1'b1;
        TxByteHS_Data     = byte_q;
        TxReadyHS         = 1'b1;
      end
      TRAIL: begin
        Serializer_Enable = 1'b1;
        TxByteHS_Data     = {8{~byte_q[7]}};
      end
      EXIT: begin
        LP_Dp = 1'b1;
        LP_Dn = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// Randomized bench for hs_tx_sequencer: expected per-cycle line trace built from burst
// descriptions (leader, payload list, trail, exit) and compared cycle by cycle.
module tb_hs_tx_sequencer;

  localparam int T_LPX  = 2;
  localparam int T_PREP = 2;
  localparam int T_ZERO = 6;
  localparam int T_TRL  = 4;
  localparam int T_EXT  = 3;
  localparam logic [7:0] SYNC = 8'hB8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [7:0]  din;
  logic        rdy;
  logic [7:0]  dout;
  logic        en;
  logic        dp;
  logic        dn;
  logic        act;
  logic [15:0] bc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hs_tx_sequencer dut (
    .TxByteClkHS      (clk),
    .TxRst            (rst),
    .TxRequestHS      (req),
    .TxDataHS         (din),
    .TxReadyHS        (rdy),
    .TxByteHS_Data    (dout),
    .Serializer_Enable(en),
    .LP_Dp            (dp),
    .LP_Dn            (dn),
`ifdef HS_BYTE_COUNT_EN
    .Burst_Byte_Count (bc),
`endif
    .Burst_Active     (act)
  );

`ifndef HS_BYTE_COUNT_EN
  assign bc = 16'h0000;
`endif

  typedef struct {
    logic        rq;
    logic [7:0]  din;
    logic        dp, dn, en, rdy, act;
    logic [7:0]  dout;
    logic [15:0] bc;
  } vec_t;

  vec_t        q[$];
  logic [7:0]  pay[$];
  logic [15:0] bc_m = 16'h0000;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic add(input logic rq, input logic [7:0] d,
                     input logic p, input logic n,
                     input logic e, input logic r,
                     input logic a, input logic [7:0] o);
    vec_t v;
    v.rq = rq; v.din = d;
    v.dp = p; v.dn = n; v.en = e; v.rdy = r; v.act = a;
    v.dout = o; v.bc = bc_m;
    q.push_back(v);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  // expected trace for one burst carrying the bytes in pay
  task automatic build(input int gap, input bit pulse);
    int n;
    logic [7:0] last;
    n = pay.size();
    for (int i = 0; i < gap; i++)
      add(i == gap - 1, rbyte(), 1, 1, 0, 0, 0, 8'h00);
    bc_m = 16'h0000;
    for (int i = 0; i < T_LPX; i++)
      add(pulse ? 1'b0 : rb(), rbyte(), 0, 1, 0, 0, 1, 8'h00);
    for (int i = 0; i < T_PREP; i++)
      add(pulse ? 1'b0 : rb(), rbyte(), 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < T_ZERO; i++)
      add(pulse ? 1'b0 : rb(), rbyte(), 0, 0, 1, 0, 1, 8'h00);
    add(n > 0, n > 0 ? pay[0] : rbyte(), 0, 0, 1, 1, 1, SYNC);
    for (int i = 0; i < n; i++) begin
      if (bc_m != 16'hFFFF) bc_m++;
      add(i + 1 < n, i + 1 < n ? pay[i+1] : rbyte(),
          0, 0, 1, 1, 1, pay[i]);
    end
    last = (n > 0) ? pay[n-1] : SYNC;
    for (int i = 0; i < T_TRL; i++)
      add(rb(), rbyte(), 0, 0, 1, 0, 1, {8{~last[7]}});
    for (int i = 0; i < T_EXT; i++)
      add(rb(), rbyte(), 1, 1, 0, 0, 1, 8'h00);
  endtask

  task automatic chk_rst();
    check("rst_dp", dp, 1);
    check("rst_dn", dn, 1);
    check("rst_en", en, 0);
    check("rst_data", dout, 0);
    check("rst_rdy", rdy, 0);
    check("rst_act", act, 0);
`ifdef HS_BYTE_COUNT_EN
    check("rst_bc", bc, 0);
`endif
  endtask

  // called at posedge+1; abort >= 0 asserts reset between edges
  task automatic play(input int abort);
    for (int k = 0; k < q.size(); k++) begin
      check("dp", dp, q[k].dp);
      check("dn", dn, q[k].dn);
      check("en", en, q[k].en);
      check("rdy", rdy, q[k].rdy);
      check("act", act, q[k].act);
      check("data", dout, q[k].dout);
`ifdef HS_BYTE_COUNT_EN
      check("bcount", bc, q[k].bc);
`endif
      if (k == abort) begin
        #3 rst = 1'b1;
        #1 chk_rst();
        @(negedge clk) rst = 1'b0;
        req = 1'b0;
        bc_m = 16'h0000;
        q.delete();
        return;
      end
      req = q[k].rq;
      din = q[k].din;
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  initial begin
    int len;
    rst = 1'b1;
    req = 1'b0;
    din = 8'h00;
    #12 chk_rst();
    @(negedge clk) rst = 1'b0;

    pay = '{8'h33, 8'hC3};
    build(2, 0); play(-1);
    pay = '{8'h57};
    build(1, 0); play(-1);
    pay.delete();
    build(3, 1); play(-1);
    pay = '{rbyte(), rbyte(), rbyte(), rbyte(), rbyte()};
    build(2, 0); play(-1);
    pay = '{8'h11, 8'h92, 8'h23, 8'hA4};
    build(1, 0);
    play(1 + T_LPX + T_PREP + T_ZERO + 2);
    pay = '{8'h80, 8'h7F};
    build(2, 0); play(-1);

    for (int b = 0; b < 20; b++) begin
      pay.delete();
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) pay.push_back(rbyte());
      build($urandom_range(1, 3), len == 0 && rb());
      play(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule
